// File: rtl/text_pkg.sv
// Shared definitions for the text overlay character path.
// Holds the tile-grid defaults, address field widths, the control codes the
// writer understands, the writer state encoding and a printable-range helper.
package text_pkg;

   localparam int COLS_DEF = 80;   // tiles per row (at most 128)
   localparam int ROWS_DEF = 30;   // tile rows (at most 32)

   localparam int COL_W  = 7;              // column field of the tile address
   localparam int ROW_W  = 5;              // row field of the tile address
   localparam int ADDR_W = ROW_W + COL_W;  // {row, col}
   localparam int CHR_W  = 7;              // 7-bit ASCII

   localparam logic [CHR_W-1:0] CHR_BS    = 7'h08;
   localparam logic [CHR_W-1:0] CHR_LF    = 7'h0A;
   localparam logic [CHR_W-1:0] CHR_FF    = 7'h0C;
   localparam logic [CHR_W-1:0] CHR_CR    = 7'h0D;
   localparam logic [CHR_W-1:0] CHR_SPACE = 7'h20;
   localparam logic [CHR_W-1:0] CHR_TILDE = 7'h7E;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,  // accepting characters
      ST_WRAP    = 2'd1,  // last-column character written, row clear pending
      ST_CLR_ROW = 2'd2,  // zeroing the row at cur_y
      ST_CLR_ALL = 2'd3   // zeroing the whole grid
   } wr_state_t;

   function automatic logic is_printable(input logic [CHR_W-1:0] code);
      return (code >= CHR_SPACE) && (code <= CHR_TILDE);
   endfunction

endpackage

// File: rtl/text_char_writer.sv
// Character-stream writer for the VGA text overlay.
// Consumes ASCII codes over a valid/ready handshake, keeps a cursor on a
// COLS x ROWS tile grid and drives the write port of the external dual-port
// tile RAM. Interprets CR, LF, BS and FF; every line advance clears the new
// row, FF clears the whole grid. All other non-printable codes are consumed
// and ignored. COLS must be at least 2.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   char_valid  char_data holds a code to consume
//   char_data   7-bit ASCII code
//   char_ready  block accepts char_data this cycle (registered)
//   we          tile RAM write strobe (registered)
//   waddr       tile address {row[4:0], col[6:0]} (registered, held when we=0)
//   wdata       code written (registered, held when we=0)
//   cur_x       cursor column 0..COLS-1
//   cur_y       cursor row 0..ROWS-1
module text_char_writer
   import text_pkg::*;
#(
   parameter int COLS = COLS_DEF,
   parameter int ROWS = ROWS_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              char_valid,
   input  logic [CHR_W-1:0]  char_data,
   output logic              char_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [CHR_W-1:0]  wdata,
   output logic [COL_W-1:0]  cur_x,
   output logic [ROW_W-1:0]  cur_y
);

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

   wr_state_t        state;
   logic [COL_W-1:0] clr_col;   // next column the clear will write
   logic [ROW_W-1:0] clr_row;   // next row the clear will write
   logic             clr_last;  // final clear address has already been issued
   logic [ROW_W-1:0] next_row;
   logic             take;

   // NOTE: every signal assigned in always_comb gets a value on every path,
   // otherwise synthesis infers a latch.
   always_comb begin
      next_row = (cur_y == LAST_ROW) ? '0 : cur_y + ROW_W'(1);
      take     = char_valid && char_ready;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         char_ready <= 1'b0;
         we         <= 1'b0;
         waddr      <= '0;
         wdata      <= '0;
         cur_x      <= '0;
         cur_y      <= '0;
         clr_col    <= '0;
         clr_row    <= '0;
         clr_last   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               char_ready <= 1'b1;
               we         <= 1'b0;
               if (take) begin
                  if (is_printable(char_data)) begin
                     we    <= 1'b1;
                     waddr <= {cur_y, cur_x};
                     wdata <= char_data;
                     if (cur_x == LAST_COL) begin
                        // Line wraps: the clear of the new row starts one
                        // cycle later, after the character write itself.
                        cur_x      <= '0;
                        cur_y      <= next_row;
                        clr_row    <= next_row;
                        clr_col    <= '0;
                        clr_last   <= 1'b0;
                        char_ready <= 1'b0;
                        state      <= ST_WRAP;
                     end else begin
                        cur_x <= cur_x + COL_W'(1);
                     end
                  end else begin
                     case (char_data)
                        CHR_CR: cur_x <= '0;
                        CHR_LF: begin
                           // First clear write goes out with the acceptance.
                           cur_x      <= '0;
                           cur_y      <= next_row;
                           char_ready <= 1'b0;
                           we         <= 1'b1;
                           waddr      <= {next_row, COL_W'(0)};
                           wdata      <= '0;
                           clr_row    <= next_row;
                           clr_col    <= COL_W'(1);
                           clr_last   <= 1'b0;
                           state      <= ST_CLR_ROW;
                        end
                        CHR_BS: begin
                           if (cur_x != '0) begin
                              cur_x <= cur_x - COL_W'(1);
                              we    <= 1'b1;
                              waddr <= {cur_y, cur_x - COL_W'(1)};
                              wdata <= '0;
                           end
                        end
                        CHR_FF: begin
                           cur_x      <= '0;
                           cur_y      <= '0;
                           char_ready <= 1'b0;
                           we         <= 1'b1;
                           waddr      <= '0;
                           wdata      <= '0;
                           clr_row    <= '0;
                           clr_col    <= COL_W'(1);
                           clr_last   <= 1'b0;
                           state      <= ST_CLR_ALL;
                        end
                        default: ;  // unsupported codes are swallowed
                     endcase
                  end
               end
            end

            ST_WRAP: begin
               we      <= 1'b1;
               waddr   <= {clr_row, clr_col};
               wdata   <= '0;
               clr_col <= clr_col + COL_W'(1);
               state   <= ST_CLR_ROW;
            end

            ST_CLR_ROW: begin
               if (clr_last) begin
                  we         <= 1'b0;
                  char_ready <= 1'b1;
                  state      <= ST_IDLE;
               end else begin
                  we       <= 1'b1;
                  waddr    <= {clr_row, clr_col};
                  wdata    <= '0;
                  clr_last <= (clr_col == LAST_COL);
                  clr_col  <= clr_col + COL_W'(1);
               end
            end

            ST_CLR_ALL: begin
               if (clr_last) begin
                  we         <= 1'b0;
                  char_ready <= 1'b1;
                  state      <= ST_IDLE;
               end else begin
                  we       <= 1'b1;
                  waddr    <= {clr_row, clr_col};
                  wdata    <= '0;
                  clr_last <= (clr_col == LAST_COL) && (clr_row == LAST_ROW);
                  if (clr_col == LAST_COL) begin
                     clr_col <= '0;
                     clr_row <= clr_row + ROW_W'(1);
                  end else begin
                     clr_col <= clr_col + COL_W'(1);
                  end
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_text_char_writer.sv
// Self-checking bench for text_char_writer: a table of single-cycle vectors
// followed by hand-written sequences for line feed, wrap, backspace and a
// reset during a full-screen clear.
module tb_text_char_writer;
   import text_pkg::*;

   localparam int COLS = 80;
   localparam int ROWS = 30;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        char_valid = 1'b0;
   logic [6:0]  char_data = '0;
   logic        char_ready;
   logic        we;
   logic [11:0] waddr;
   logic [6:0]  wdata;
   logic [6:0]  cur_x;
   logic [4:0]  cur_y;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   text_char_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clk        (clk),
      .reset      (reset),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_ready (char_ready),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .cur_x      (cur_x),
      .cur_y      (cur_y)
   );

   typedef struct {
      logic        valid;
      logic [6:0]  data;
      logic        we;
      logic [11:0] waddr;
      logic [6:0]  wdata;
      logic [6:0]  x;
      logic [4:0]  y;
      logic        ready;
   } vec_t;

   vec_t vecs[11];

   function automatic logic [11:0] ta(input int r, input int c);
      return 12'((r << 7) | c);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge; presents one code for one edge and returns at the
   // following negedge with the registered result visible.
   task automatic send(input logic [6:0] code);
      char_valid = 1'b1;
      char_data  = code;
      @(posedge clk);
      @(negedge clk);
      char_valid = 1'b0;
   endtask

   task automatic wait_ready(input int budget);
      int n = 0;
      while (!char_ready && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("wait_ready", 32'(char_ready), 32'd1);
   endtask

   // Expects COLS consecutive clear writes to a row, ready held low, then
   // ready high with no write in the following cycle.
   task automatic expect_row_clear(input int row);
      for (int i = 0; i < COLS; i++) begin
         check($sformatf("clr_r%0d_c%0d", row, i),
               32'({we, char_ready, waddr, wdata}),
               32'({1'b1, 1'b0, ta(row, i), 7'h00}));
         @(negedge clk);
      end
      check($sformatf("clr_r%0d_done", row), 32'({we, char_ready}), 32'b01);
   endtask

   initial begin
      // {valid, data} -> {we, waddr, wdata, x, y, ready} after the edge
      vecs[0]  = '{1'b1, 7'h48, 1'b1, ta(0, 0), 7'h48, 7'd1, 5'd0, 1'b1};
      vecs[1]  = '{1'b1, 7'h69, 1'b1, ta(0, 1), 7'h69, 7'd2, 5'd0, 1'b1};
      vecs[2]  = '{1'b0, 7'h00, 1'b0, ta(0, 1), 7'h69, 7'd2, 5'd0, 1'b1};
      vecs[3]  = '{1'b1, 7'h07, 1'b0, ta(0, 1), 7'h69, 7'd2, 5'd0, 1'b1};
      vecs[4]  = '{1'b1, 7'h7F, 1'b0, ta(0, 1), 7'h69, 7'd2, 5'd0, 1'b1};
      vecs[5]  = '{1'b1, 7'h0D, 1'b0, ta(0, 1), 7'h69, 7'd0, 5'd0, 1'b1};
      vecs[6]  = '{1'b1, 7'h08, 1'b0, ta(0, 1), 7'h69, 7'd0, 5'd0, 1'b1};
      vecs[7]  = '{1'b1, 7'h7E, 1'b1, ta(0, 0), 7'h7E, 7'd1, 5'd0, 1'b1};
      vecs[8]  = '{1'b1, 7'h20, 1'b1, ta(0, 1), 7'h20, 7'd2, 5'd0, 1'b1};
      vecs[9]  = '{1'b1, 7'h08, 1'b1, ta(0, 1), 7'h00, 7'd1, 5'd0, 1'b1};
      vecs[10] = '{1'b1, 7'h1F, 1'b0, ta(0, 1), 7'h00, 7'd1, 5'd0, 1'b1};

      // Reset state
      #12;
      check("reset_outputs", 32'({char_ready, we, waddr, wdata, cur_x, cur_y}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      check("ready_before_edge", 32'(char_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("ready_after_reset", 32'(char_ready), 32'd1);

      // Table-driven single-cycle vectors
      for (int i = 0; i < 11; i++) begin
         char_valid = vecs[i].valid;
         char_data  = vecs[i].data;
         @(posedge clk);
         @(negedge clk);
         char_valid = 1'b0;
         check($sformatf("vec%0d", i),
               32'({we, waddr, wdata, cur_x, cur_y, char_ready}),
               32'({vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].x, vecs[i].y, vecs[i].ready}));
      end

      // Move to y=3, x=5
      for (int i = 0; i < 3; i++) begin
         send(CHR_LF);
         wait_ready(100);
      end
      for (int i = 0; i < 5; i++) send(7'h61);
      check("pos_before_lf", 32'({cur_x, cur_y}), 32'({7'd5, 5'd3}));

      // LF from (5,3): cursor moves at acceptance, row 4 cleared over 80 cycles
      send(CHR_LF);
      check("lf_cursor", 32'({cur_x, cur_y}), 32'({7'd0, 5'd4}));
      expect_row_clear(4);

      // Advance to row 29, then fill it to force the wrap
      for (int i = 0; i < 25; i++) begin
         send(CHR_LF);
         wait_ready(100);
      end
      check("pos_row29", 32'({cur_x, cur_y}), 32'({7'd0, 5'd29}));
      for (int i = 0; i < COLS - 1; i++) begin
         send(7'h41);
         check($sformatf("fill_c%0d", i), 32'({we, waddr, wdata, char_ready}),
               32'({1'b1, ta(29, i), 7'h41, 1'b1}));
      end
      send(7'h41);
      check("wrap_char_write", 32'({we, waddr, wdata, char_ready}),
            32'({1'b1, ta(29, 79), 7'h41, 1'b0}));
      check("wrap_cursor", 32'({cur_x, cur_y}), 32'({7'd0, 5'd0}));
      @(negedge clk);
      expect_row_clear(0);

      // BS at x=0 is a no-op
      send(CHR_BS);
      check("bs_at_0", 32'({we, cur_x, cur_y, char_ready}), 32'({1'b0, 7'd0, 5'd0, 1'b1}));

      // BS at (7,2)
      for (int i = 0; i < 2; i++) begin
         send(CHR_LF);
         wait_ready(100);
      end
      for (int i = 0; i < 7; i++) send(7'h30 + 7'(i));
      send(CHR_BS);
      check("bs_write", 32'({we, waddr, wdata, char_ready}), 32'({1'b1, ta(2, 6), 7'h00, 1'b1}));
      check("bs_cursor", 32'({cur_x, cur_y}), 32'({7'd6, 5'd2}));

      // FF mid-line, reset during the 100th clear write
      send(CHR_FF);
      check("ff_first", 32'({we, waddr, wdata, cur_x, cur_y, char_ready}),
            32'({1'b1, ta(0, 0), 7'h00, 7'd0, 5'd0, 1'b0}));
      for (int i = 0; i < 99; i++) @(negedge clk);
      check("ff_write100", 32'({we, waddr, char_ready}), 32'({1'b1, ta(1, 19), 1'b0}));
      reset = 1'b1;
      #1;
      check("ff_reset_outputs", 32'({char_ready, we, waddr, wdata, cur_x, cur_y}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("ff_after_release", 32'({char_ready, we, cur_x, cur_y}), 32'({1'b1, 1'b0, 7'd0, 5'd0}));
      @(negedge clk);
      check("ff_no_resume", 32'({char_ready, we}), 32'b10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
